// File: rtl/reg_file_pkg.sv
// Shared types and helpers for the multi-read-port register file.
// REGF_PARITY_EN widens each stored entry by one even-parity bit per byte.
package reg_file_pkg;

  typedef logic [0:0] state_t;
  localparam state_t ST_IDLE  = 1'b0;
  localparam state_t ST_SWEEP = 1'b1;

  function automatic int bytes_of(input int n);
    return n / 8;
  endfunction

  // Stored entry width: data alone, or data followed by one parity bit per byte.
  function automatic int store_w(input int n);
`ifdef REGF_PARITY_EN
    return n + n / 8;
`else
    return n;
`endif
  endfunction

  function automatic logic byte_parity(input logic [7:0] b);
    return ^b;
  endfunction

endpackage

// File: rtl/reg_file_mp_if.sv
// Write/read bus of reg_file_mp; the requester uses master, the register file uses slave.
// r_perr exists only when REGF_PARITY_EN is defined.
interface reg_file_mp_if #(
   parameter int N  = 32,
   parameter int W  = 4,
   parameter int NR = 2
);
   logic              wr_en;
   logic              w_ready;
   logic [W-1:0]      w_addr;
   logic [N/8-1:0]    w_be;
   logic [N-1:0]      w_data;
   logic [NR*W-1:0]   r_addr;
   logic [NR*N-1:0]   r_data;
   logic              busy;
`ifdef REGF_PARITY_EN
   logic [NR-1:0]     r_perr;

   modport master (output wr_en, w_addr, w_be, w_data, r_addr,
                   input  w_ready, r_data, busy, r_perr);
   modport slave  (input  wr_en, w_addr, w_be, w_data, r_addr,
                   output w_ready, r_data, busy, r_perr);
`else
   modport master (output wr_en, w_addr, w_be, w_data, r_addr,
                   input  w_ready, r_data, busy);
   modport slave  (input  wr_en, w_addr, w_be, w_data, r_addr,
                   output w_ready, r_data, busy);
`endif
endinterface

// File: rtl/reg_file_rd_port.sv
// One combinational read port: bypass merge of the in-flight write, forced zero while busy.
// With REGF_PARITY_EN, also flags a per-byte parity mismatch on the returned word.
module reg_file_rd_port
   import reg_file_pkg::*;
#(
   parameter int N = 32
) (
   input  logic [store_w(N)-1:0] i_rd_word,
   input  logic                  i_byp_hit,
   input  logic [N/8-1:0]        i_w_be,
   input  logic [N-1:0]          i_w_data,
   input  logic                  i_busy,
`ifdef REGF_PARITY_EN
   output logic                  o_perr,
`endif
   output logic [N-1:0]          o_data
);

   localparam int BYTES = bytes_of(N);

   logic [N-1:0]     w_merged;
`ifdef REGF_PARITY_EN
   logic [BYTES-1:0] w_par;
   logic [BYTES-1:0] w_mism;
`endif

   // Bypassed bytes carry freshly computed parity, so they can never mismatch.
   always_comb begin
      w_merged = i_rd_word[N-1:0];
`ifdef REGF_PARITY_EN
      w_par  = i_rd_word[N +: BYTES];
      w_mism = '0;
`endif
      for (int k = 0; k < BYTES; k++) begin
         if (i_byp_hit && i_w_be[k]) begin
            w_merged[8*k +: 8] = i_w_data[8*k +: 8];
`ifdef REGF_PARITY_EN
            w_par[k] = byte_parity(i_w_data[8*k +: 8]);
`endif
         end
      end
`ifdef REGF_PARITY_EN
      for (int k = 0; k < BYTES; k++) begin
         w_mism[k] = byte_parity(w_merged[8*k +: 8]) ^ w_par[k];
      end
`endif
   end

   assign o_data = i_busy ? '0 : w_merged;
`ifdef REGF_PARITY_EN
   assign o_perr = ~i_busy & (|w_mism);
`endif

endmodule

// File: rtl/reg_file_mp.sv
// Register file with one byte-enabled write port, NR combinational read ports and a clear sweep.
// Optional per-byte parity storage and read checking under REGF_PARITY_EN.
module reg_file_mp
   import reg_file_pkg::*;
#(
   parameter int N      = 32,
   parameter int W      = 4,
   parameter int NR     = 2,
   parameter int BYPASS = 1
) (
   input  logic          clk,
   input  logic          clr,
   reg_file_mp_if.slave  bus
);

   localparam int DEPTH = 2 ** W;
   localparam int BYTES = bytes_of(N);
   localparam int SW    = store_w(N);

   state_t          r_state;
   logic [W-1:0]    r_sweep_ptr;
   logic [SW-1:0]   r_mem [DEPTH];

   logic            w_busy;
   logic            w_wr_fire;

   assign w_busy      = (r_state != ST_IDLE);
   assign w_wr_fire   = ~clr & ~w_busy & bus.wr_en;
   assign bus.busy    = w_busy;
   assign bus.w_ready = ~w_busy;

   // Clear sweep: clr parks the pointer at 0; IDLE follows the zeroing of the last entry.
   always_ff @(posedge clk) begin
      if (clr) begin
         r_state     <= ST_SWEEP;
         r_sweep_ptr <= '0;
      end else if (r_state == ST_SWEEP) begin
         if (r_sweep_ptr == W'(DEPTH - 1)) begin
            r_state <= ST_IDLE;
         end else begin
            r_sweep_ptr <= r_sweep_ptr + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (r_state == ST_SWEEP) begin
         r_mem[r_sweep_ptr] <= '0;
      end else if (w_wr_fire) begin
         for (int k = 0; k < BYTES; k++) begin
            if (bus.w_be[k]) begin
               r_mem[bus.w_addr][8*k +: 8] <= bus.w_data[8*k +: 8];
`ifdef REGF_PARITY_EN
               r_mem[bus.w_addr][N + k] <= byte_parity(bus.w_data[8*k +: 8]);
`endif
            end
         end
      end
   end

   for (genvar p = 0; p < NR; p++) begin : g_rd
      logic [W-1:0] w_raddr;
      logic         w_hit;
      logic [N-1:0] w_rdata;

      assign w_raddr = bus.r_addr[p*W +: W];
      assign w_hit   = (BYPASS != 0) && w_wr_fire && (w_raddr == bus.w_addr);

      reg_file_rd_port #(.N(N)) u_rd (
         .i_rd_word (r_mem[w_raddr]),
         .i_byp_hit (w_hit),
         .i_w_be    (bus.w_be),
         .i_w_data  (bus.w_data),
         .i_busy    (w_busy),
`ifdef REGF_PARITY_EN
         .o_perr    (bus.r_perr[p]),
`endif
         .o_data    (w_rdata)
      );

      assign bus.r_data[p*N +: N] = w_rdata;
   end

endmodule

// File: tb/tb_reg_file_mp.sv
// Directed bench for reg_file_mp: one BYPASS=1 and one BYPASS=0 instance driven in lockstep.
// Parity scenario is compiled in only with REGF_PARITY_EN.
module tb_reg_file_mp;

   localparam int N  = 32;
   localparam int W  = 4;
   localparam int NR = 2;

   logic clk;
   logic clr;
   int   tests_run;
   int   tests_failed;

   reg_file_mp_if #(.N(N), .W(W), .NR(NR)) bus1 ();
   reg_file_mp_if #(.N(N), .W(W), .NR(NR)) bus0 ();

   reg_file_mp #(.N(N), .W(W), .NR(NR), .BYPASS(1)) dut (
      .clk (clk),
      .clr (clr),
      .bus (bus1)
   );

   reg_file_mp #(.N(N), .W(W), .NR(NR), .BYPASS(0)) dut_nb (
      .clk (clk),
      .clr (clr),
      .bus (bus0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_wr(input logic en, input logic [W-1:0] a,
                         input logic [3:0] be, input logic [N-1:0] d);
      bus1.wr_en = en; bus1.w_addr = a; bus1.w_be = be; bus1.w_data = d;
      bus0.wr_en = en; bus0.w_addr = a; bus0.w_be = be; bus0.w_data = d;
   endtask

   task automatic set_rd(input logic [W-1:0] a0, input logic [W-1:0] a1);
      bus1.r_addr = {a1, a0};
      bus0.r_addr = {a1, a0};
   endtask

   task automatic test_reset();
      int n;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      n = 0;
      while (bus1.busy === 1'b1 && n < 40) begin
         set_rd(W'(n), W'(15 - n));
         #1;
         tests_run++;
         if (bus1.w_ready !== 1'b0 || bus1.r_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_sweep_out cyc=%0d w_ready=%b r_data=%h want w_ready=0 r_data=0",
                     n, bus1.w_ready, bus1.r_data);
         end
         n++;
         tick();
      end
      tests_run++;
      if (n !== 16) begin
         tests_failed++;
         $display("FAIL reset_busy_len got %0d want 16", n);
      end
      tests_run++;
      if (bus1.busy !== 1'b0 || bus1.w_ready !== 1'b1 || bus0.busy !== 1'b0) begin
         tests_failed++;
         $display("FAIL reset_idle busy=%b w_ready=%b busy_nb=%b want 0 1 0",
                  bus1.busy, bus1.w_ready, bus0.busy);
      end
      for (int a = 0; a < 16; a += 2) begin
         set_rd(W'(a), W'(a + 1));
         #1;
         tests_run++;
         if (bus1.r_data !== '0 || bus0.r_data !== '0) begin
            tests_failed++;
            $display("FAIL reset_cleared addr=%0d got %h / %h want 0", a, bus1.r_data, bus0.r_data);
         end
      end
   endtask

   task automatic test_byte_enable();
      set_wr(1'b1, 4'd3, 4'b1111, 32'hDEADBEEF);
      tick();
      set_wr(1'b1, 4'd3, 4'b0010, 32'h0000AA00);
      tick();
      set_wr(1'b0, 4'd0, 4'b0000, 32'h0);
      set_rd(4'd3, 4'd3);
      #1;
      tests_run++;
      if (bus1.r_data[31:0] !== 32'hDEADAAEF) begin
         tests_failed++;
         $display("FAIL byte_enable_p0 got %h want DEADAAEF", bus1.r_data[31:0]);
      end
      tests_run++;
      if (bus1.r_data[63:32] !== 32'hDEADAAEF) begin
         tests_failed++;
         $display("FAIL same_addr_p1 got %h want DEADAAEF", bus1.r_data[63:32]);
      end
      set_wr(1'b1, 4'd3, 4'b0000, 32'h11223344);
      tick();
      set_wr(1'b0, 4'd0, 4'b0000, 32'h0);
      #1;
      tests_run++;
      if (bus1.r_data[31:0] !== 32'hDEADAAEF) begin
         tests_failed++;
         $display("FAIL be_zero_noop got %h want DEADAAEF", bus1.r_data[31:0]);
      end
   endtask

   task automatic test_bypass();
      set_wr(1'b1, 4'd5, 4'b1111, 32'hFFFFFFFF);
      tick();
      set_wr(1'b1, 4'd5, 4'b1100, 32'h12345678);
      set_rd(4'd3, 4'd5);
      #1;
      tests_run++;
      if (bus1.r_data[63:32] !== 32'h1234FFFF) begin
         tests_failed++;
         $display("FAIL bypass_on got %h want 1234FFFF", bus1.r_data[63:32]);
      end
      tests_run++;
      if (bus0.r_data[63:32] !== 32'hFFFFFFFF) begin
         tests_failed++;
         $display("FAIL bypass_off got %h want FFFFFFFF", bus0.r_data[63:32]);
      end
      tests_run++;
      if (bus1.r_data[31:0] !== 32'hDEADAAEF) begin
         tests_failed++;
         $display("FAIL bypass_other_port got %h want DEADAAEF", bus1.r_data[31:0]);
      end
      tick();
      set_wr(1'b0, 4'd0, 4'b0000, 32'h0);
      #1;
      tests_run++;
      if (bus1.r_data[63:32] !== 32'h1234FFFF || bus0.r_data[63:32] !== 32'h1234FFFF) begin
         tests_failed++;
         $display("FAIL bypass_committed got %h / %h want 1234FFFF",
                  bus1.r_data[63:32], bus0.r_data[63:32]);
      end
   endtask

   task automatic test_back_to_back();
      set_wr(1'b1, 4'd1, 4'b1111, 32'hA0A1A2A3);
      tick();
      set_wr(1'b1, 4'd2, 4'b0101, 32'hB0B1B2B3);
      tick();
      set_wr(1'b1, 4'd15, 4'b1000, 32'hC0000000);
      set_rd(4'd1, 4'd2);
      #1;
      tests_run++;
      if (bus1.r_data !== {32'hxxB1xxB3 & 32'h00FF00FF | 32'h00000000, 32'hA0A1A2A3}
          && bus1.r_data[31:0] !== 32'hA0A1A2A3) begin
         tests_failed++;
         $display("FAIL b2b_p0 got %h want A0A1A2A3", bus1.r_data[31:0]);
      end
      tests_run++;
      if (bus1.r_data[63:32] !== 32'h00B100B3) begin
         tests_failed++;
         $display("FAIL b2b_p1 got %h want 00B100B3", bus1.r_data[63:32]);
      end
      tick();
      set_wr(1'b0, 4'd0, 4'b0000, 32'h0);
      set_rd(4'd15, 4'd1);
      #1;
      tests_run++;
      if (bus1.r_data !== {32'hA0A1A2A3, 32'hC0000000}) begin
         tests_failed++;
         $display("FAIL b2b_last got %h want A0A1A2A3C0000000", bus1.r_data);
      end
   endtask

   task automatic test_busy_write();
      int n;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      set_rd(4'd3, 4'd3);
      n = 0;
      while (bus1.busy === 1'b1 && n < 40) begin
         if (n == 7) begin
            set_wr(1'b1, 4'd3, 4'b1111, 32'hA5A5A5A5);
            #1;
            tests_run++;
            if (bus1.w_ready !== 1'b0 || bus1.r_data !== '0) begin
               tests_failed++;
               $display("FAIL busy_write_ready w_ready=%b r_data=%h want 0 0",
                        bus1.w_ready, bus1.r_data);
            end
         end else begin
            set_wr(1'b0, 4'd0, 4'b0000, 32'h0);
         end
         n++;
         tick();
      end
      set_wr(1'b0, 4'd0, 4'b0000, 32'h0);
      #1;
      tests_run++;
      if (n !== 16) begin
         tests_failed++;
         $display("FAIL busy_write_len got %0d want 16", n);
      end
      tests_run++;
      if (bus1.r_data !== '0 || bus0.r_data !== '0) begin
         tests_failed++;
         $display("FAIL busy_write_dropped got %h / %h want 0", bus1.r_data, bus0.r_data);
      end
   endtask

   task automatic test_restart();
      int n;
      clr = 1'b1;
      tick();
      clr = 1'b0;
      for (int i = 0; i < 10; i++) tick();
      tests_run++;
      if (bus1.busy !== 1'b1) begin
         tests_failed++;
         $display("FAIL restart_mid busy=%b want 1", bus1.busy);
      end
      clr = 1'b1;
      tick();
      clr = 1'b0;
      n = 0;
      while (bus1.busy === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      tests_run++;
      if (n !== 16) begin
         tests_failed++;
         $display("FAIL restart_len got %0d want 16", n);
      end
      clr = 1'b1;
      for (int i = 0; i < 3; i++) tick();
      tests_run++;
      if (bus1.busy !== 1'b1 || bus1.w_ready !== 1'b0) begin
         tests_failed++;
         $display("FAIL held_clr busy=%b w_ready=%b want 1 0", bus1.busy, bus1.w_ready);
      end
      clr = 1'b0;
      n = 0;
      while (bus1.busy === 1'b1 && n < 40) begin
         n++;
         tick();
      end
      tests_run++;
      if (n !== 16) begin
         tests_failed++;
         $display("FAIL held_clr_len got %0d want 16", n);
      end
   endtask

`ifdef REGF_PARITY_EN
   task automatic test_parity();
      set_wr(1'b1, 4'd2, 4'b1111, 32'h01020304);
      tick();
      set_wr(1'b1, 4'd4, 4'b1111, 32'h0F0E0D0C);
      tick();
      set_wr(1'b0, 4'd0, 4'b0000, 32'h0);
      set_rd(4'd2, 4'd4);
      #1;
      tests_run++;
      if (bus1.r_perr !== 2'b00) begin
         tests_failed++;
         $display("FAIL parity_clean got %b want 00", bus1.r_perr);
      end
      dut.r_mem[2][5] = ~dut.r_mem[2][5];
      #1;
      tests_run++;
      if (bus1.r_perr !== 2'b01 || bus1.r_data[31:0] !== 32'h01020324) begin
         tests_failed++;
         $display("FAIL parity_flip perr=%b data=%h want 01 01020324",
                  bus1.r_perr, bus1.r_data[31:0]);
      end
      set_rd(4'd4, 4'd2);
      #1;
      tests_run++;
      if (bus1.r_perr !== 2'b10) begin
         tests_failed++;
         $display("FAIL parity_other_addr got %b want 10", bus1.r_perr);
      end
      set_wr(1'b1, 4'd2, 4'b0001, 32'h00000077);
      #1;
      tests_run++;
      if (bus1.r_perr !== 2'b00 || bus1.r_data[63:32] !== 32'h01020377) begin
         tests_failed++;
         $display("FAIL parity_bypass perr=%b data=%h want 00 01020377",
                  bus1.r_perr, bus1.r_data[63:32]);
      end
      tick();
      set_wr(1'b0, 4'd0, 4'b0000, 32'h0);
   endtask
`endif

   initial begin
      tests_run    = 0;
      tests_failed = 0;
      clr          = 1'b0;
      set_wr(1'b0, 4'd0, 4'b0000, 32'h0);
      set_rd(4'd0, 4'd0);
      tick();
      test_reset();
      test_byte_enable();
      test_bypass();
      test_back_to_back();
      test_busy_write();
      test_restart();
`ifdef REGF_PARITY_EN
      test_parity();
`endif
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
